// File: rtl/dec139_scan_ctrl_if.sv
// Control and decoder-drive signals of the dual 2-to-4 decoder scan sequencer.
// The controller drives en/single; the sequencer drives everything else.
interface dec139_scan_ctrl_if;
    logic       en;
    logic       single;
    logic       g_l1;
    logic       g_l2;
    logic       a1;
    logic       b1;
    logic       a2;
    logic       b2;
    logic [2:0] idx;
    logic       busy;
    logic       done;

    modport master (
        output en, single,
        input  g_l1, g_l2, a1, b1, a2, b2, idx, busy, done
    );

    modport slave (
        input  en, single,
        output g_l1, g_l2, a1, b1, a2, b2, idx, busy, done
    );
endinterface

// File: rtl/dec139_scan_ctrl.sv
// Scan sequencer for a 74x139-style dual decoder: steps indices 0..7 with a programmable
// dwell and blanking gap, continuous or single-pass; every output comes straight from a flop.
module dec139_scan_ctrl #(
    parameter int unsigned Dwell = 4,
    parameter int unsigned Blank = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    dec139_scan_ctrl_if.slave scan_io
);

    typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

    localparam logic [7:0] DwellLast = 8'(Dwell - 1);
    localparam logic [7:0] BlankLast = (Blank == 0) ? 8'd0 : 8'(Blank - 1);
    localparam bit         HasBlank  = (Blank != 0);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;
    logic       armed_q, armed_d;
    logic       done_q, done_d;
    logic       busy_q;
    logic       en_q, single_q;
    logic       advance;
    logic       g_l1_q, g_l1_d, g_l2_q, g_l2_d;
    logic       a1_q, a1_d, b1_q, b1_d, a2_q, a2_d, b2_q, b2_d;

    // Next-state logic acts on the registered en/single, giving the one-edge start/abort latency.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        armed_d = armed_q | ~en_q;
        done_d  = 1'b0;
        advance = 1'b0;

        if (state_q != StIdle && !en_q) begin
            state_d = StIdle;
            idx_d   = 3'd0;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en_q && armed_q) begin
                        state_d = StDrive;
                        idx_d   = 3'd0;
                        cnt_d   = 8'd0;
                        mode_d  = single_q;
                    end
                end
                StDrive: begin
                    if (cnt_q == DwellLast) begin
                        cnt_d = 8'd0;
                        if (HasBlank) state_d = StGap;
                        else          advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == BlankLast) begin
                        cnt_d   = 8'd0;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (advance) begin
            if (idx_q != 3'd7) begin
                idx_d   = idx_q + 3'd1;
                state_d = StDrive;
            end else if (!mode_q) begin
                idx_d   = 3'd0;
                state_d = StDrive;
            end else begin
                idx_d   = 3'd0;
                state_d = StIdle;
                done_d  = 1'b1;
                armed_d = 1'b0;
            end
        end
    end

    // Decoder pins are decoded from the next state so they land in flops with the state.
    always_comb begin
        g_l1_d = 1'b1;
        g_l2_d = 1'b1;
        a1_d   = 1'b0;
        b1_d   = 1'b0;
        a2_d   = 1'b0;
        b2_d   = 1'b0;
        if (state_d != StIdle) begin
            if (!idx_d[2]) begin
                a1_d   = idx_d[0];
                b1_d   = idx_d[1];
                g_l1_d = (state_d != StDrive);
            end else begin
                a2_d   = idx_d[0];
                b2_d   = idx_d[1];
                g_l2_d = (state_d != StDrive);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            idx_q    <= 3'd0;
            cnt_q    <= 8'd0;
            mode_q   <= 1'b0;
            armed_q  <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            en_q     <= 1'b0;
            single_q <= 1'b0;
            g_l1_q   <= 1'b1;
            g_l2_q   <= 1'b1;
            a1_q     <= 1'b0;
            b1_q     <= 1'b0;
            a2_q     <= 1'b0;
            b2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            armed_q  <= armed_d;
            done_q   <= done_d;
            busy_q   <= (state_d != StIdle);
            en_q     <= scan_io.en;
            single_q <= scan_io.single;
            g_l1_q   <= g_l1_d;
            g_l2_q   <= g_l2_d;
            a1_q     <= a1_d;
            b1_q     <= b1_d;
            a2_q     <= a2_d;
            b2_q     <= b2_d;
        end
    end

    assign scan_io.g_l1 = g_l1_q;
    assign scan_io.g_l2 = g_l2_q;
    assign scan_io.a1   = a1_q;
    assign scan_io.b1   = b1_q;
    assign scan_io.a2   = a2_q;
    assign scan_io.b2   = b2_q;
    assign scan_io.idx  = idx_q;
    assign scan_io.busy = busy_q;
    assign scan_io.done = done_q;

endmodule

// File: tb/tb_dec139_scan_ctrl.sv
// Directed bench for dec139_scan_ctrl: three instances cover default timing,
// continuous DWELL=2/BLANK=0, and the DWELL=1/BLANK=255 counter boundary.
module tb_dec139_scan_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    dec139_scan_ctrl_if if0 ();
    dec139_scan_ctrl_if if1 ();
    dec139_scan_ctrl_if if2 ();

    dec139_scan_ctrl #(.Dwell(4), .Blank(1)) u_def (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .scan_io (if0)
    );

    dec139_scan_ctrl #(.Dwell(2), .Blank(0)) u_cont (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .scan_io (if1)
    );

    dec139_scan_ctrl #(.Dwell(1), .Blank(255)) u_bnd (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .scan_io (if2)
    );

    // {g_l1, g_l2, b1, a1, b2, a2, idx, busy, done}
    wire [10:0] st0 = {if0.g_l1, if0.g_l2, if0.b1, if0.a1, if0.b2, if0.a2, if0.idx, if0.busy,
                       if0.done};
    wire [10:0] st1 = {if1.g_l1, if1.g_l2, if1.b1, if1.a1, if1.b2, if1.a2, if1.idx, if1.busy,
                       if1.done};
    wire [10:0] st2 = {if2.g_l1, if2.g_l2, if2.b1, if2.a1, if2.b2, if2.a2, if2.idx, if2.busy,
                       if2.done};

    localparam logic [10:0] IdleSt = 11'b11_0000_000_0_0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hand-derived pin pattern {g_l1, g_l2, b1, a1, b2, a2} while driving index i.
    function automatic logic [5:0] pins_drive(input logic [2:0] i);
        if (!i[2]) return {2'b01, i[1], i[0], 2'b00};
        else       return {2'b10, 2'b00, i[1], i[0]};
    endfunction

    function automatic logic [10:0] drive_st(input logic [2:0] i);
        return {pins_drive(i), i, 1'b1, 1'b0};
    endfunction

    function automatic logic [10:0] gap_st(input logic [2:0] i);
        logic [5:0] p;
        p = pins_drive(i);
        return {2'b11, p[3:0], i, 1'b1, 1'b0};
    endfunction

    task automatic test_reset;
        rst_n      = 1'b0;
        if0.en     = 1'b1;
        if1.en     = 1'b1;
        if2.en     = 1'b1;
        if0.single = 1'b1;
        if1.single = 1'b0;
        if2.single = 1'b0;
        tick; tick; tick;
        n_checks++;
        if (st0 !== IdleSt) $display("FAIL reset_def: got %h want %h", st0, IdleSt);
        else n_pass++;
        n_checks++;
        if (st1 !== IdleSt) $display("FAIL reset_cont: got %h want %h", st1, IdleSt);
        else n_pass++;
        n_checks++;
        if (st2 !== IdleSt) $display("FAIL reset_bnd: got %h want %h", st2, IdleSt);
        else n_pass++;
        if0.en = 1'b0;
        if1.en = 1'b0;
        if2.en = 1'b0;
        rst_n  = 1'b1;
        tick;
    endtask

    task automatic test_single_pass;
        logic ok;
        if0.en     = 1'b1;
        if0.single = 1'b1;
        tick;
        n_checks++;
        if (st0 !== IdleSt) $display("FAIL start_latency: got %h want %h", st0, IdleSt);
        else n_pass++;
        tick;
        if0.single = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 4; d++) begin
                n_checks++;
                if (st0 !== drive_st(i[2:0]))
                    $display("FAIL single_drive i=%0d d=%0d: got %h want %h", i, d, st0,
                             drive_st(i[2:0]));
                else n_pass++;
                tick;
            end
            n_checks++;
            if (st0 !== gap_st(i[2:0]))
                $display("FAIL single_gap i=%0d: got %h want %h", i, st0, gap_st(i[2:0]));
            else n_pass++;
            tick;
        end
        n_checks++;
        if (st0 !== (IdleSt | 11'd1))
            $display("FAIL single_done: got %h want %h", st0, IdleSt | 11'd1);
        else n_pass++;
        tick;
        n_checks++;
        if (st0 !== IdleSt) $display("FAIL done_fall: got %h want %h", st0, IdleSt);
        else n_pass++;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (st0 !== IdleSt) ok = 1'b0;
            tick;
        end
        n_checks++;
        if (ok !== 1'b1) $display("FAIL no_restart: got %b want 1", ok);
        else n_pass++;
    endtask

    task automatic test_rearm;
        if0.en = 1'b0;
        tick;
        if0.en = 1'b1;
        tick;
        n_checks++;
        if (st0 !== IdleSt) $display("FAIL rearm_wait: got %h want %h", st0, IdleSt);
        else n_pass++;
        tick;
        n_checks++;
        if (st0 !== drive_st(3'd0))
            $display("FAIL rearm_start: got %h want %h", st0, drive_st(3'd0));
        else n_pass++;
        if0.en = 1'b0;
        tick; tick;
        n_checks++;
        if (st0 !== IdleSt) $display("FAIL rearm_stop: got %h want %h", st0, IdleSt);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        if0.en     = 1'b1;
        if0.single = 1'b1;
        tick; tick;
        n_checks++;
        if (st0 !== drive_st(3'd0))
            $display("FAIL areset_pre: got %h want %h", st0, drive_st(3'd0));
        else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (st0 !== IdleSt) $display("FAIL areset_async: got %h want %h", st0, IdleSt);
        else n_pass++;
        #1 rst_n = 1'b1;
        if0.en = 1'b0;
        tick;
    endtask

    task automatic test_continuous;
        logic [2:0] i;
        if1.en     = 1'b1;
        if1.single = 1'b0;
        tick; tick;
        for (int c = 0; c < 18; c++) begin
            i = 3'((c / 2) % 8);
            n_checks++;
            if (st1 !== drive_st(i))
                $display("FAIL cont c=%0d: got %h want %h", c, st1, drive_st(i));
            else n_pass++;
            tick;
        end
    endtask

    task automatic test_abort;
        for (int k = 0; k < 40 && if1.idx !== 3'd5; k++) tick;
        n_checks++;
        if (st1 !== drive_st(3'd5))
            $display("FAIL abort_reach5: got %h want %h", st1, drive_st(3'd5));
        else n_pass++;
        if1.en = 1'b0;
        tick;
        n_checks++;
        if (st1 !== drive_st(3'd5))
            $display("FAIL abort_lat: got %h want %h", st1, drive_st(3'd5));
        else n_pass++;
        tick;
        n_checks++;
        if (st1 !== IdleSt) $display("FAIL abort_idle: got %h want %h", st1, IdleSt);
        else n_pass++;
        tick;
        n_checks++;
        if (st1 !== IdleSt) $display("FAIL abort_nodone: got %h want %h", st1, IdleSt);
        else n_pass++;
    endtask

    task automatic test_boundary;
        logic       ok;
        logic [2:0] i;
        if2.en     = 1'b1;
        if2.single = 1'b0;
        tick; tick;
        for (int n = 0; n < 9; n++) begin
            i = 3'(n % 8);
            n_checks++;
            if (st2 !== drive_st(i))
                $display("FAIL bnd_drive n=%0d: got %h want %h", n, st2, drive_st(i));
            else n_pass++;
            tick;
            ok = 1'b1;
            for (int b = 0; b < 255; b++) begin
                if (st2 !== gap_st(i)) ok = 1'b0;
                tick;
            end
            n_checks++;
            if (ok !== 1'b1) $display("FAIL bnd_gap n=%0d: got %b want 1", n, ok);
            else n_pass++;
        end
        n_checks++;
        if (st2 !== drive_st(3'd1))
            $display("FAIL bnd_next: got %h want %h", st2, drive_st(3'd1));
        else n_pass++;
        if2.en = 1'b0;
        tick; tick;
        n_checks++;
        if (st2 !== IdleSt) $display("FAIL bnd_stop: got %h want %h", st2, IdleSt);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset;
        test_single_pass;
        test_rearm;
        test_async_reset;
        test_continuous;
        test_abort;
        test_boundary;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
